mem_responder: RTL and testbench

//   Unified instruction/data memory responder on the far side of the multicycle core's memory port.

---
 rtl/mem_responder_pkg.sv | 34 +++
 rtl/mem_responder_lane_align.sv | 40 ++++
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: funct3 size codes, FSM states and lane helpers.
package mem_responder_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } mem_state_t;

   function automatic logic f3Legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Byte offset inside the word after forcing the access down to its natural alignment.
   function automatic logic [1:0] alignOffset(input logic [2:0] f3, input logic [1:0] lo);
      logic [1:0] off;
      case (f3[1:0])
         2'b00:   off = lo;
         2'b01:   off = {lo[1], 1'b0};
         default: off = 2'b00;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/mem_responder_lane_align.sv
// Combinational lane steering: store byte enables and data replication, load lane extraction
// with sign or zero extension.
module mem_responder_lane_align
   import mem_responder_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  byte_en_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   assign byteLane = rword_i[{offset_i, 3'b000} +: 8];
   assign halfLane = offset_i[1] ? rword_i[31:16] : rword_i[15:0];

   always_comb begin
      byte_en_o = 4'b1111;
      wdata_o   = wdata_i;
      rdata_o   = rword_i;
      case (funct3_i[1:0])
         2'b00: begin
            byte_en_o = 4'b0001 << offset_i;
            wdata_o   = {4{wdata_i[7:0]}};
            rdata_o   = funct3_i[2] ? {24'b0, byteLane} : {{24{byteLane[7]}}, byteLane};
         end
         2'b01: begin
            byte_en_o = offset_i[1] ? 4'b1100 : 4'b0011;
            wdata_o   = {2{wdata_i[15:0]}};
            rdata_o   = funct3_i[2] ? {16'b0, halfLane} : {{16{halfLane[15]}}, halfLane};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data memory responder with programmable wait states and RISC-V sizing.
// Define MEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning down.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int    DEPTH_WORDS = 1024,
   parameter int    WAIT_STATES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [WAIT_CNT_W-1:0] CNT_INIT = WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   mem_state_t            state_q;
   logic [WAIT_CNT_W-1:0] cnt_q;
   logic                  we_q;
   logic [31:0]           addr_q;
   logic [2:0]            funct3_q;
   logic [31:0]           wdata_q;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic [31:0]           rsp_rdata_q;
   logic                  rsp_err_q;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [IDX_W-1:0] wordIdx;
   logic [31:0]      rword;
   logic [3:0]       byteEn;
   logic [31:0]      wdataRep;
   logic [31:0]      loadData;
   logic             outOfRange;
   logic             badFunct3;
   logic             err_d;

   assign wordIdx    = addr_q[IDX_W+1:2];
   assign rword      = mem_q[wordIdx];
   assign outOfRange = addr_q[31:2] >= 30'(DEPTH_WORDS);
   assign badFunct3  = !f3Legal(funct3_q) || (we_q && funct3_q[2]);

`ifdef MEM_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                       ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
   assign err_d      = outOfRange || badFunct3 || misaligned;
`else
   assign err_d      = outOfRange || badFunct3;
`endif

   mem_responder_lane_align uLaneAlign (
      .funct3_i  (funct3_q),
      .offset_i  (alignOffset(funct3_q, addr_q[1:0])),
      .wdata_i   (wdata_q),
      .rword_i   (rword),
      .byte_en_o (byteEn),
      .wdata_o   (wdataRep),
      .rdata_o   (loadData)
   );

   // Request/response sequencing; every port-facing output is a register updated here.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         funct3_q    <= '0;
         wdata_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i && req_ready_q) begin
                  we_q        <= req_we_i;
                  addr_q      <= req_addr_i;
                  funct3_q    <= req_funct3_i;
                  wdata_q     <= req_wdata_i;
                  req_ready_q <= 1'b0;
                  if (WAIT_STATES == 0) begin
                     state_q <= ACCESS;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= ACCESS;
               end else begin
                  cnt_q <= cnt_q - WAIT_CNT_W'(1);
               end
            end
            ACCESS: begin
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= err_d;
               rsp_rdata_q <= (we_q || err_d) ? 32'b0 : loadData;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Storage is never reset; an async reset forces IDLE, which kills any pending store.
   always_ff @(posedge clk_i) begin
      if ((state_q == ACCESS) && we_q && !err_d) begin
         for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) begin
               mem_q[wordIdx][8*i +: 8] <= wdataRep[8*i +: 8];
            end
         end
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a byte-addressed reference model predicts each response,
// and an independent monitor compares whatever the DUT presents.
module tb_mem_responder;

   localparam int DEPTH = 1024;
   localparam int WS    = 1;

   logic        clk;
   logic        rstN;
   logic        reqValid;
   logic        reqReady;
   logic        reqWe;
   logic [31:0] reqAddr;
   logic [2:0]  reqFunct3;
   logic [31:0] reqWdata;
   logic        rspValid;
   logic        rspReady;
   logic [31:0] rspRdata;
   logic        rspErr;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          acceptCyc;
   } exp_t;

   exp_t       expQ[$];
   exp_t       monE;
   logic [7:0] modelMem [int];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   bit         rspSeen = 0;
   bit         rspRandom = 0;
   logic       rspForce = 1'b1;
   logic [31:0] held;

   mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES (WS),
      .INIT_FILE   ("")
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .req_valid_i  (reqValid),
      .req_ready_o  (reqReady),
      .req_we_i     (reqWe),
      .req_addr_i   (reqAddr),
      .req_funct3_i (reqFunct3),
      .req_wdata_i  (reqWdata),
      .rsp_valid_o  (rspValid),
      .rsp_ready_i  (rspReady),
      .rsp_rdata_o  (rspRdata),
      .rsp_err_o    (rspErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // The response-ready line changes just after each rising edge so the monitor sees it settled.
   always @(posedge clk) begin
      #1;
      rspReady = rspRandom ? 1'($urandom_range(0, 1)) : rspForce;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Reference model: memory as individual bytes, accesses as little-endian byte groups.
   function automatic exp_t modelAccess(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                        input logic [31:0] wdata);
      exp_t        e;
      int          size;
      logic [31:0] a;
      logic [31:0] v;
      e.err       = 1'b0;
      e.rdata     = 32'h0;
      e.acceptCyc = 0;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e.err = 1'b1;
      if (we && f3[2]) e.err = 1'b1;
      if (addr >= 32'(4 * DEPTH)) e.err = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
      if ((addr % size) != 0) e.err = 1'b1;
`endif
      a = addr - (addr % size);
      if (!e.err) begin
         if (we) begin
            for (int i = 0; i < size; i++) modelMem[int'(a) + i] = wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(modelMem[int'(a) + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 32'h1);
            e.rdata = v;
         end
      end
      return e;
   endfunction

   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wdata);
      exp_t e;
      int   budget;
      @(negedge clk);
      reqValid  = 1'b1;
      reqWe     = we;
      reqAddr   = addr;
      reqFunct3 = f3;
      reqWdata  = wdata;
      budget    = 0;
      while (!reqReady && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (!reqReady) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept timeout: req_ready=%0b, required 1", reqReady);
         reqValid = 1'b0;
         return;
      end
      @(posedge clk);
      e = modelAccess(we, addr, f3, wdata);
      #1;
      e.acceptCyc = cyc;
      expQ.push_back(e);
      reqValid = 1'b0;
   endtask

   task automatic waitDrain();
      int budget = 0;
      while ((expQ.size() != 0 || rspValid) && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("drain", 32'(expQ.size()), 32'h0);
   endtask

   // Monitor: latency on first sight of each response, data/err on the handshake.
   always @(negedge clk) begin
      if (rstN && rspValid) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected response: rdata=0x%08h err=%0b, required none", rspRdata, rspErr);
         end else begin
            if (!rspSeen) begin
               checkOutput("latency", 32'(cyc - expQ[0].acceptCyc), 32'(WS + 1));
               rspSeen = 1'b1;
            end
            if (rspReady) begin
               monE = expQ.pop_front();
               checkOutput("rdata", rspRdata, monE.rdata);
               checkOutput("err", 32'(rspErr), 32'(monE.err));
               rspSeen = 1'b0;
            end
         end
      end
   end

   initial begin
      rstN      = 1'b0;
      reqValid  = 1'b0;
      reqWe     = 1'b0;
      reqAddr   = '0;
      reqFunct3 = '0;
      reqWdata  = '0;
      rspReady  = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset req_ready", 32'(reqReady), 32'h1);
      checkOutput("reset rsp_valid", 32'(rspValid), 32'h0);
      checkOutput("reset rsp_rdata", rspRdata, 32'h0);
      checkOutput("reset rsp_err", 32'(rspErr), 32'h0);
      rstN = 1'b1;

      for (int w = 0; w < 32; w++) applyStimulus(1'b1, 32'(4 * w), 3'b010, $urandom);
      applyStimulus(1'b1, 32'(4 * DEPTH - 4), 3'b010, $urandom);

      applyStimulus(1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
      applyStimulus(1'b0, 32'h10, 3'b010, 32'h0);
      applyStimulus(1'b1, 32'h10, 3'b010, 32'h11223344);
      applyStimulus(1'b1, 32'h13, 3'b000, 32'h00000080);
      applyStimulus(1'b0, 32'h13, 3'b000, 32'h0);
      applyStimulus(1'b0, 32'h13, 3'b100, 32'h0);
      applyStimulus(1'b0, 32'h10, 3'b010, 32'h0);
      applyStimulus(1'b1, 32'h22, 3'b001, 32'h00008001);
      applyStimulus(1'b0, 32'h22, 3'b001, 32'h0);
      applyStimulus(1'b0, 32'h22, 3'b101, 32'h0);
      applyStimulus(1'b0, 32'h20, 3'b010, 32'h0);

      applyStimulus(1'b0, 32'(4 * DEPTH), 3'b010, 32'h0);
      applyStimulus(1'b1, 32'(4 * DEPTH), 3'b010, 32'h55AA55AA);
      applyStimulus(1'b0, 32'hFFFFFFFC, 3'b010, 32'h0);
      applyStimulus(1'b0, 32'(4 * DEPTH - 4), 3'b010, 32'h0);
      applyStimulus(1'b0, 32'h10, 3'b011, 32'h0);
      applyStimulus(1'b1, 32'h10, 3'b100, 32'h000000FF);
      applyStimulus(1'b1, 32'h10, 3'b111, 32'hFFFFFFFF);
      applyStimulus(1'b0, 32'h10, 3'b010, 32'h0);

      applyStimulus(1'b0, 32'h11, 3'b010, 32'h0);
      applyStimulus(1'b0, 32'h13, 3'b001, 32'h0);
      applyStimulus(1'b1, 32'h21, 3'b010, 32'h0BADF00D);
      applyStimulus(1'b0, 32'h20, 3'b010, 32'h0);
      waitDrain();

      // Back-pressure: response held for five cycles with the core not ready.
      rspForce = 1'b0;
      applyStimulus(1'b0, 32'h20, 3'b010, 32'h0);
      for (int b = 0; b < 20 && !rspValid; b++) @(negedge clk);
      checkOutput("stall rsp_valid rise", 32'(rspValid), 32'h1);
      held = rspRdata;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("stall rsp_valid", 32'(rspValid), 32'h1);
         checkOutput("stall rsp_rdata", rspRdata, held);
         checkOutput("stall req_ready", 32'(reqReady), 32'h0);
      end
      rspForce = 1'b1;
      waitDrain();

      // Reset while a store sits in the wait state: the store must vanish.
      @(negedge clk);
      reqValid  = 1'b1;
      reqWe     = 1'b1;
      reqAddr   = 32'h10;
      reqFunct3 = 3'b010;
      reqWdata  = 32'hCAFEF00D;
      @(posedge clk);
      #1 reqValid = 1'b0;
      #1 rstN = 1'b0;
      #1;
      checkOutput("midreset rsp_valid", 32'(rspValid), 32'h0);
      checkOutput("midreset req_ready", 32'(reqReady), 32'h1);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1'b0, 32'h10, 3'b010, 32'h0);
      waitDrain();

      rspRandom = 1'b1;
      for (int n = 0; n < 300; n++) begin
         int          r;
         logic [2:0]  f3;
         logic [31:0] addr;
         logic        we;
         logic [2:0]  legal [5];
         logic [2:0]  illegal [3];
         legal   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
         illegal = '{3'd3, 3'd6, 3'd7};
         r    = int'($urandom_range(0, 19));
         we   = 1'($urandom_range(0, 1));
         f3   = legal[$urandom_range(0, 4)];
         addr = 32'($urandom_range(0, 127));
         if (r == 0) addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
         if (r == 1) f3 = illegal[$urandom_range(0, 2)];
         applyStimulus(we, addr, f3, $urandom);
      end
      waitDrain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
